sme_master: RTL

//  Front end and result merger for the parallel string-matching engine.
//  - Captures a byte-serial string and pattern.
//  - Splits the candidate start positions across NUM_SLAVE pe_slave instances and launches them.
//  - Collects their per-slave results and reports the earliest match position.

---
 rtl/sme_master.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sme_master.sv
// Front end and result merger for the parallel string-matching engine: buffers a string and a
// pattern, splits the start positions across NUM_SLAVE slaves and reports the earliest match.
module sme_master #(
  parameter int unsigned NUM_SLAVE = 4,
  parameter int unsigned MAX_STR   = 32,
  parameter int unsigned MAX_PAT   = 8,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [7:0]                    chardata_i,
  input  logic                          isstring_i,
  input  logic                          ispattern_i,
  output logic                          ready_o,
  output logic                          valid_o,
  output logic                          match_o,
  output logic [ADDR_W-1:0]             match_index_o,
  output logic [MAX_STR*8-1:0]          slv_str_o,
  output logic [MAX_PAT*8-1:0]          slv_pat_o,
  output logic [NUM_SLAVE-1:0]          slv_input_valid_o,
  output logic [NUM_SLAVE*ADDR_W-1:0]   slv_start_idx_o,
  output logic [NUM_SLAVE*ADDR_W-1:0]   slv_process_2idx_o,
  input  logic [NUM_SLAVE-1:0]          slv_output_valid_i,
  input  logic [NUM_SLAVE-1:0]          slv_match_i,
  input  logic [NUM_SLAVE*ADDR_W-1:0]   slv_match_idx_i
);

  localparam int unsigned StrLenW  = $clog2(MAX_STR + 1);
  localparam int unsigned PatLenW  = $clog2(MAX_PAT + 1);
  localparam int unsigned PosW     = StrLenW + 1;
  localparam int unsigned SlvShift = $clog2(NUM_SLAVE);
  localparam logic [StrLenW-1:0] StrMax = StrLenW'(MAX_STR);
  localparam logic [PatLenW-1:0] PatMax = PatLenW'(MAX_PAT);

  typedef enum logic [2:0] {StIdle, StLoadStr, StLoadPat, StDispatch, StWait, StDone} state_e;

  state_e                        state_q, state_d;
  logic [MAX_STR*8-1:0]          str_q, str_d;
  logic [MAX_PAT*8-1:0]          pat_q, pat_d;
  logic [StrLenW-1:0]            str_len_q, str_len_d;
  logic [PatLenW-1:0]            pat_len_q, pat_len_d;
  logic [NUM_SLAVE*ADDR_W-1:0]   start_q, start_d, end_q, end_d, idx_q, idx_d;
  logic [NUM_SLAVE-1:0]          active_q, active_d, launch_q, launch_d;
  logic [NUM_SLAVE-1:0]          done_q, done_d, hit_q, hit_d;
  logic                          valid_q, valid_d, match_q, match_d;
  logic [ADDR_W-1:0]             match_index_q, match_index_d;

  logic [StrLenW-1:0]            wr_s;
  logic [PatLenW-1:0]            wr_p;
  logic [PosW-1:0]               npos, chunk, seg_s, seg_e;
  logic                          seg_act;

  always_comb begin
    state_d       = state_q;
    str_d         = str_q;
    pat_d         = pat_q;
    str_len_d     = str_len_q;
    pat_len_d     = pat_len_q;
    start_d       = start_q;
    end_d         = end_q;
    idx_d         = idx_q;
    active_d      = active_q;
    done_d        = done_q;
    hit_d         = hit_q;
    launch_d      = '0;
    valid_d       = 1'b0;
    match_d       = 1'b0;
    match_index_d = '0;
    wr_s          = '0;
    wr_p          = '0;
    npos          = '0;
    chunk         = '0;
    seg_s         = '0;
    seg_e         = '0;
    seg_act       = 1'b0;

    unique case (state_q)
      StIdle, StLoadStr, StLoadPat: begin
        if (isstring_i) begin
          // A fresh string burst restarts at byte 0; overflow bytes are dropped.
          wr_s = (state_q == StLoadStr) ? str_len_q : '0;
          if (wr_s < StrMax) begin
            for (int i = 0; i < MAX_STR; i++) begin
              if (wr_s == StrLenW'(i)) str_d[8*i +: 8] = chardata_i;
            end
            str_len_d = wr_s + 1'b1;
          end else begin
            str_len_d = wr_s;
          end
          state_d = StLoadStr;
        end else if (ispattern_i) begin
          wr_p = (state_q == StLoadPat) ? pat_len_q : '0;
          if (wr_p < PatMax) begin
            for (int i = 0; i < MAX_PAT; i++) begin
              if (wr_p == PatLenW'(i)) pat_d[8*i +: 8] = chardata_i;
            end
            pat_len_d = wr_p + 1'b1;
          end else begin
            pat_len_d = wr_p;
          end
          state_d = StLoadPat;
        end else if (state_q == StLoadPat) begin
          state_d = StDispatch;
        end else begin
          state_d = StIdle;
        end
      end

      StDispatch: begin
        npos     = PosW'(str_len_q) - PosW'(pat_len_q) + PosW'(1);
        chunk    = (npos + PosW'(NUM_SLAVE - 1)) >> SlvShift;
        done_d   = '0;
        hit_d    = '0;
        idx_d    = '0;
        active_d = '0;
        start_d  = '0;
        end_d    = '0;
        if (pat_len_q == '0) begin
          state_d = StDone;
          valid_d = 1'b1;
          match_d = 1'b1;
        end else if (PosW'(pat_len_q) > PosW'(str_len_q)) begin
          state_d = StDone;
          valid_d = 1'b1;
        end else begin
          for (int k = 0; k < NUM_SLAVE; k++) begin
            seg_s = PosW'(k) * chunk;
            seg_e = seg_s + chunk - PosW'(1);
            if (seg_e > npos - PosW'(1)) seg_e = npos - PosW'(1);
            seg_act     = (seg_s <= npos - PosW'(1));
            active_d[k] = seg_act;
            if (seg_act) begin
              start_d[k*ADDR_W +: ADDR_W] = seg_s[ADDR_W-1:0];
              end_d[k*ADDR_W +: ADDR_W]   = seg_e[ADDR_W-1:0];
            end
          end
          launch_d = active_d;
          state_d  = StWait;
        end
      end

      StWait: begin
        for (int k = 0; k < NUM_SLAVE; k++) begin
          if (slv_output_valid_i[k] && active_q[k] && !done_q[k]) begin
            done_d[k]                 = 1'b1;
            hit_d[k]                  = slv_match_i[k];
            idx_d[k*ADDR_W +: ADDR_W] = slv_match_idx_i[k*ADDR_W +: ADDR_W];
          end
        end
        if (&(done_d | ~active_q)) begin
          state_d = StDone;
          valid_d = 1'b1;
          match_d = |hit_d;
          // Slave ranges ascend with k, so the lowest hitting slave holds the earliest match.
          for (int k = NUM_SLAVE - 1; k >= 0; k--) begin
            if (hit_d[k]) match_index_d = idx_d[k*ADDR_W +: ADDR_W];
          end
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      str_q         <= '0;
      pat_q         <= '0;
      str_len_q     <= '0;
      pat_len_q     <= '0;
      start_q       <= '0;
      end_q         <= '0;
      idx_q         <= '0;
      active_q      <= '0;
      launch_q      <= '0;
      done_q        <= '0;
      hit_q         <= '0;
      valid_q       <= 1'b0;
      match_q       <= 1'b0;
      match_index_q <= '0;
    end else begin
      state_q       <= state_d;
      str_q         <= str_d;
      pat_q         <= pat_d;
      str_len_q     <= str_len_d;
      pat_len_q     <= pat_len_d;
      start_q       <= start_d;
      end_q         <= end_d;
      idx_q         <= idx_d;
      active_q      <= active_d;
      launch_q      <= launch_d;
      done_q        <= done_d;
      hit_q         <= hit_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      match_index_q <= match_index_d;
    end
  end

  assign ready_o            = (state_q == StIdle) || (state_q == StLoadStr) ||
                              (state_q == StLoadPat);
  assign valid_o            = valid_q;
  assign match_o            = match_q;
  assign match_index_o      = match_index_q;
  assign slv_str_o          = str_q;
  assign slv_pat_o          = pat_q;
  assign slv_input_valid_o  = launch_q;
  assign slv_start_idx_o    = start_q;
  assign slv_process_2idx_o = end_q;

endmodule
